// File: rtl/step_counter_pkg.sv
// Shared constants for step_counter and the code that drives it.
//   DIR_UP / DIR_DOWN   : values of the 'up' input
//   MODE_WRAP / MODE_SAT: values of the 'sat' input
package step_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/step_counter_next.sv
// Combinational next-count unit for step_counter.
// Ports:
//   q         : current count
//   up        : 1 = add STEP, 0 = subtract STEP
//   sat       : 1 = clamp at the range edge, 0 = wrap within [0, lim]
//   lim       : inclusive upper bound of the count range
//   q_next    : count after one enabled step
//   limit_hit : the step clamped or wrapped at a range edge
module step_counter_next
  import step_counter_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned STEP      = 1
) (
  input  logic [DATAWIDTH-1:0] q,
  input  logic                 up,
  input  logic                 sat,
  input  logic [DATAWIDTH-1:0] lim,
  output logic [DATAWIDTH-1:0] q_next,
  output logic                 limit_hit
);

  localparam int unsigned WideW = DATAWIDTH + 1;
  localparam logic [DATAWIDTH:0] StepWide = WideW'(STEP);
  localparam logic [DATAWIDTH:0] OneWide  = WideW'(1);

  // One extra bit keeps q+STEP and lim+1 exact even when lim is all-ones.
  logic [DATAWIDTH:0]   q_wide;
  logic [DATAWIDTH:0]   lim_wide;
  logic [DATAWIDTH:0]   span;
  logic [DATAWIDTH:0]   sum;
  logic [DATAWIDTH-1:0] up_wrap;
  logic [DATAWIDTH-1:0] dn_step;
  logic [DATAWIDTH-1:0] dn_wrap;

  assign q_wide   = {1'b0, q};
  assign lim_wide = {1'b0, lim};
  assign span     = lim_wide + OneWide;
  assign sum      = q_wide + StepWide;
  // Each result below is known to fit in DATAWIDTH bits on the path that uses it.
  assign up_wrap  = DATAWIDTH'(sum - span);
  assign dn_step  = DATAWIDTH'(q_wide - StepWide);
  assign dn_wrap  = DATAWIDTH'(q_wide + span - StepWide);

  always_comb begin
    q_next    = q;
    limit_hit = 1'b0;
    if (q > lim) begin
      // Out of range after a load or a lim change: pull back to the bound.
      q_next = lim;
    end else if (up == DIR_UP) begin
      if (sum <= lim_wide) begin
        q_next = sum[DATAWIDTH-1:0];
      end else begin
        limit_hit = 1'b1;
        q_next    = (sat == MODE_SAT) ? lim : up_wrap;
      end
    end else begin
      if (q_wide >= StepWide) begin
        q_next = dn_step;
      end else begin
        limit_hit = 1'b1;
        q_next    = (sat == MODE_SAT) ? '0 : dn_wrap;
      end
    end
  end

endmodule

// File: rtl/step_counter.sv
// Registered up/down counter with configurable step, run-time bound and
// per-cycle saturate/wrap choice.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load, d  : load d into q (unchecked against lim)
//   en       : take one step this cycle
//   up, sat  : direction and saturate/wrap mode, used only on enabled steps
//   lim      : inclusive upper bound of the count range
//   q        : registered count
//   tc       : registered one-cycle pulse when a step clamps or wraps
//   zero     : q == 0, decoded straight from the q register
module step_counter
  import step_counter_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned STEP      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATAWIDTH-1:0] d,
  input  logic                 en,
  input  logic                 up,
  input  logic                 sat,
  input  logic [DATAWIDTH-1:0] lim,
  output logic [DATAWIDTH-1:0] q,
  output logic                 tc,
  output logic                 zero
);

  logic [DATAWIDTH-1:0] q_next;
  logic                 limit_hit;

  step_counter_next #(
    .DATAWIDTH(DATAWIDTH),
    .STEP     (STEP)
  ) u_next (
    .q        (q),
    .up       (up),
    .sat      (sat),
    .lim      (lim),
    .q_next   (q_next),
    .limit_hit(limit_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (load) begin
      q  <= d;
      tc <= 1'b0;
    end else if (en) begin
      q  <= q_next;
      tc <= limit_hit;
    end else begin
      tc <= 1'b0;
    end
  end

  assign zero = (q == '0);

endmodule

// File: tb/tb_step_counter.sv
module tb_step_counter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] d = '0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         sat = 1'b0;
  logic [W-1:0] lim = 8'd255;

  logic [W-1:0] q1, q3;
  logic         tc1, tc3, zero1, zero3;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference state for the STEP=1 (index 0) and STEP=3 (index 1) counters.
  int m_q [2];
  int m_tc[2];
  int steps[2] = '{1, 3};

  always #5 clk = ~clk;

  step_counter #(.DATAWIDTH(W), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .d(d), .en(en), .up(up), .sat(sat),
    .lim(lim), .q(q1), .tc(tc1), .zero(zero1)
  );

  step_counter #(.DATAWIDTH(W), .STEP(3)) dut3 (
    .clk(clk), .rst(rst), .load(load), .d(d), .en(en), .up(up), .sat(sat),
    .lim(lim), .q(q3), .tc(tc3), .zero(zero3)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural rules in plain integer arithmetic: range is [0, lim], a step
  // beyond either edge either clamps or wraps modulo lim+1.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int s, l, nq, nt;
      s  = steps[i];
      l  = int'(lim);
      nq = m_q[i];
      nt = 0;
      if (rst) nq = 0;
      else if (load) nq = int'(d);
      else if (en) begin
        if (m_q[i] > l) nq = l;
        else if (up) begin
          if (m_q[i] + s <= l) nq = m_q[i] + s;
          else begin
            nt = 1;
            nq = sat ? l : (m_q[i] + s) % (l + 1);
          end
        end else begin
          if (m_q[i] - s >= 0) nq = m_q[i] - s;
          else begin
            nt = 1;
            nq = sat ? 0 : m_q[i] - s + (l + 1);
          end
        end
      end
      m_q[i]  <= nq;
      m_tc[i] <= nt;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("q_step1", int'(q1), m_q[0]);
      chk("tc_step1", int'(tc1), m_tc[0]);
      chk("zero_step1", int'(zero1), int'(m_q[0] == 0));
      chk("q_step3", int'(q3), m_q[1]);
      chk("tc_step3", int'(tc3), m_tc[1]);
      chk("zero_step3", int'(zero3), int'(m_q[1] == 0));
    end
  end

  // Apply one cycle of inputs, then wait until just after the capturing edge.
  task automatic cyc(input logic r, input logic ld, input int dv, input logic e,
                     input logic u, input logic s, input int lv);
    @(negedge clk);
    rst  = r;
    load = ld;
    d    = W'(dv);
    en   = e;
    up   = u;
    sat  = s;
    lim  = W'(lv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_q[5];
    int exp_tc[5];

    // Reset dominates load and en.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 'hAA, 1'b1, 1'b1, 1'b0, 255);
      cmp_en = 1'b1;
      chk("rst_q", int'(q1), 0);
      chk("rst_tc", int'(tc1), 0);
      chk("rst_zero", int'(zero1), 1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 'hAA, 1'b0, 1'b1, 1'b0, 255);
      chk("idle_q", int'(q1), 0);
    end

    // Saturating down, STEP=1.
    cyc(1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 255);
    chk("satdn_load", int'(q1), 3);
    exp_q  = '{2, 1, 0, 0, 0};
    exp_tc = '{0, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 255);
      chk("satdn_q", int'(q1), exp_q[i]);
      chk("satdn_tc", int'(tc1), exp_tc[i]);
      chk("satdn_zero", int'(zero1), int'(i >= 2));
    end

    // Wrapping down with bound, STEP=3.
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 9);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 9);
    chk("wrapdn_q0", int'(q3), 8);
    chk("wrapdn_tc0", int'(tc3), 1);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 9);
    chk("wrapdn_q1", int'(q3), 5);
    chk("wrapdn_tc1", int'(tc3), 0);

    // Wrapping up at full range, STEP=1.
    cyc(1'b0, 1'b1, 254, 1'b0, 1'b1, 1'b0, 255);
    exp_q  = '{255, 0, 1, 2, 3};
    exp_tc = '{0, 1, 0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 255);
      chk("wrapup_q", int'(q1), exp_q[i]);
      chk("wrapup_tc", int'(tc1), exp_tc[i]);
    end

    // Out of range and load-over-en priority.
    cyc(1'b0, 1'b1, 20, 1'b0, 1'b1, 1'b0, 9);
    chk("oor_load", int'(q1), 20);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 9);
    chk("oor_clamp_q", int'(q1), 9);
    chk("oor_clamp_tc", int'(tc1), 0);
    chk("oor_clamp_q3", int'(q3), 9);
    cyc(1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b0, 9);
    chk("prio_load_q", int'(q1), 4);
    chk("prio_load_q3", int'(q3), 4);

    // Random soak; lim kept >= 2 so both STEP=1 and STEP=3 stay legal.
    for (int i = 0; i < 10000; i++) begin
      int lv;
      lv = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(2, 20));
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
          int'($urandom_range(0, 255)), ($urandom_range(0, 9) < 7),
          1'($urandom), 1'($urandom), lv);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
